// File: rtl/calc_key_ctrl.sv
// Calculator keypad front end: key FIFO, signed operand/operator assembly, calculator handshake, display word.
// Optional watchdog on the calculator handshake is enabled with CALC_TIMEOUT_EN.
module calc_key_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned KEY_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     sw_clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic                     key_full,
  output logic                     key_drop,
  output logic signed [DATA_W-1:0] operand1,
  output logic signed [DATA_W-1:0] operand2,
  output logic [2:0]               operator,
  output logic                     cal_start,
  input  logic                     cal_done,
  input  logic signed [DATA_W-1:0] cal_ans,
  input  logic                     cal_err,
  output logic [31:0]              fnd_serial,
  output logic [2:0]               state_dbg
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned PTR_W = $clog2(KEY_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] LIM_POS = DATA_W'(pow10(DIGITS - 1));
  localparam logic [DATA_W-1:0] LIM_NEG = DATA_W'(pow10(DIGITS - 2));

  localparam logic [2:0] S_IDLE = 3'd0, S_OPND1 = 3'd1, S_OPER = 3'd2, S_OPND2 = 3'd3,
                         S_CALC = 3'd4, S_RESULT = 3'd5, S_ERROR = 3'd6;
  localparam logic [2:0] OP_EQU = 3'd0, OP_TIMES = 3'd1, OP_DIV = 3'd2, OP_PLUS = 3'd3,
                         OP_MINUS = 3'd4, OP_MOD = 3'd5;
  localparam logic [3:0] K_DIV = 4'hA, K_MUL = 4'hB, K_SGN = 4'hC, K_AC = 4'hD,
                         K_ANS = 4'hE, K_EQ = 4'hF;

  if (KEY_DEPTH < 2 || (KEY_DEPTH & (KEY_DEPTH - 1)) != 0 || DIGITS < 2 || TIMEOUT_CYC < 1)
  begin : g_param_err
    $error("calc_key_ctrl: unsupported parameter set");
  end

  // Operator keys: A toggles DIV/MOD, C toggles PLUS/MINUS, B selects TIMES
  function automatic logic [2:0] op_apply(input logic [2:0] cur, input logic [3:0] k);
    logic [2:0] r;
    r = cur;
    case (k)
      K_DIV:   r = (cur == OP_DIV) ? OP_MOD : OP_DIV;
      K_SGN:   r = (cur == OP_PLUS) ? OP_MINUS : OP_PLUS;
      K_MUL:   r = OP_TIMES;
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fnd_word(input logic signed [DATA_W-1:0] x);
    return 32'(x);
  endfunction

  logic [3:0]        key_mem [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  key_cnt, key_cnt_nxt;
  logic              push_c, pop_c, have_c, digit_c;
  logic [3:0]        head_c;

  logic [2:0]               state, state_nxt, oper_nxt;
  logic signed [DATA_W-1:0] op1_nxt, op2_nxt, last_ans, last_ans_nxt, x_dig_c, x_ans_c;
  logic [DATA_W-1:0]        mag, mag_nxt, mag_dig_c, lim_c;
  logic                     sign, sign_nxt, entered, entered_nxt, cal_start_nxt, wd_expired_c;
  logic [3:0]               pend_key, pend_nxt;
  logic [31:0]              fnd_nxt;

  assign have_c      = (key_cnt != '0);
  assign head_c      = key_mem[rd_ptr];
  assign digit_c     = (head_c <= 4'd9);
  assign push_c      = key_valid & ~key_full;
  assign key_cnt_nxt = key_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
  assign state_dbg   = state;

  always_ff @(posedge sw_clk) begin
    if (push_c) key_mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      key_cnt  <= '0;
      key_full <= 1'b0;
      key_drop <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      key_cnt  <= key_cnt_nxt;
      key_full <= (key_cnt_nxt == CNT_W'(KEY_DEPTH));
      key_drop <= key_valid & key_full;
    end
  end

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired_c = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst)                wd_cnt <= '0;
    else if (state != S_CALC) wd_cnt <= '0;
    else if (!wd_expired_c)   wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  assign wd_expired_c = 1'b0;
`endif

  // Negative operands get one digit less so the sign fits the display
  assign lim_c     = sign ? LIM_NEG : LIM_POS;
  assign mag_dig_c = (mag < lim_c) ? (mag * DATA_W'(10)) + DATA_W'(head_c) : mag;
  assign x_dig_c   = sign ? -mag_dig_c : mag_dig_c;
  assign x_ans_c   = sign ? -last_ans : last_ans;

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      operand1   <= '0;
      operand2   <= '0;
      operator   <= OP_EQU;
      sign       <= 1'b0;
      entered    <= 1'b0;
      mag        <= '0;
      last_ans   <= '0;
      pend_key   <= '0;
      fnd_serial <= 32'h00CC_0000;
      cal_start  <= 1'b0;
    end else begin
      state      <= state_nxt;
      operand1   <= op1_nxt;
      operand2   <= op2_nxt;
      operator   <= oper_nxt;
      sign       <= sign_nxt;
      entered    <= entered_nxt;
      mag        <= mag_nxt;
      last_ans   <= last_ans_nxt;
      pend_key   <= pend_nxt;
      fnd_serial <= fnd_nxt;
      cal_start  <= cal_start_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    op1_nxt       = operand1;
    op2_nxt       = operand2;
    oper_nxt      = operator;
    sign_nxt      = sign;
    entered_nxt   = entered;
    mag_nxt       = mag;
    last_ans_nxt  = last_ans;
    pend_nxt      = pend_key;
    fnd_nxt       = fnd_serial;
    cal_start_nxt = 1'b0;
    pop_c         = 1'b0;
    // AC at the FIFO head overrides everything, including a same-cycle cal_done
    if (have_c && head_c == K_AC) begin
      pop_c       = 1'b1;
      state_nxt   = S_IDLE;
      op1_nxt     = '0;
      op2_nxt     = '0;
      oper_nxt    = OP_EQU;
      sign_nxt    = 1'b0;
      entered_nxt = 1'b0;
      mag_nxt     = '0;
      pend_nxt    = '0;
      fnd_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          op1_nxt     = '0;
          op2_nxt     = '0;
          oper_nxt    = OP_EQU;
          sign_nxt    = 1'b0;
          entered_nxt = 1'b0;
          mag_nxt     = '0;
          if (have_c) state_nxt = S_OPND1;
        end
        S_OPND1, S_OPND2: if (have_c) begin
          if (digit_c) begin
            pop_c       = 1'b1;
            mag_nxt     = mag_dig_c;
            entered_nxt = 1'b1;
            if (state == S_OPND1) op1_nxt = x_dig_c;
            else                  op2_nxt = x_dig_c;
            fnd_nxt = fnd_word(x_dig_c);
          end else if (head_c == K_ANS) begin
            pop_c = 1'b1;
            if (!entered) begin
              mag_nxt     = last_ans;
              entered_nxt = 1'b1;
              if (state == S_OPND1) op1_nxt = x_ans_c;
              else                  op2_nxt = x_ans_c;
              fnd_nxt = sign ? 32'hE0B0_0000 : 32'h00B0_0000;
            end
          end else if (!entered) begin
            pop_c = 1'b1;
            if (head_c == K_SGN) begin
              sign_nxt = ~sign;
              fnd_nxt  = sign ? 32'h0000_0000 : 32'hE000_0000;
            end
          end else if (state == S_OPND1) begin
            state_nxt = S_OPER;
          end else begin
            pop_c         = 1'b1;
            pend_nxt      = head_c;
            cal_start_nxt = 1'b1;
            state_nxt     = S_CALC;
          end
        end
        S_OPER: begin
          if (have_c) begin
            if (digit_c) begin
              state_nxt   = S_OPND2;
              sign_nxt    = 1'b0;
              entered_nxt = 1'b0;
              mag_nxt     = '0;
            end else begin
              pop_c    = 1'b1;
              oper_nxt = op_apply(operator, head_c);
            end
          end
          fnd_nxt = {9'b0, oper_nxt, 20'h0};
        end
        S_CALC: begin
          if (cal_done) begin
            if (cal_err) begin
              state_nxt = S_ERROR;
              fnd_nxt   = 32'h00EE_0000;
            end else begin
              last_ans_nxt = cal_ans;
              if (pend_key == K_EQ) begin
                state_nxt = S_RESULT;
                fnd_nxt   = fnd_word(cal_ans);
              end else begin
                // Chaining: the answer becomes operand1 of a fresh expression
                op1_nxt     = cal_ans;
                op2_nxt     = '0;
                oper_nxt    = op_apply(OP_EQU, pend_key);
                sign_nxt    = 1'b0;
                entered_nxt = 1'b0;
                mag_nxt     = '0;
                state_nxt   = S_OPER;
              end
            end
          end else if (wd_expired_c) begin
            state_nxt = S_ERROR;
            fnd_nxt   = 32'h00EE_0000;
          end
        end
        S_RESULT: if (have_c) begin
          if (digit_c || head_c == K_ANS) begin
            op1_nxt     = '0;
            op2_nxt     = '0;
            oper_nxt    = OP_EQU;
            sign_nxt    = 1'b0;
            entered_nxt = 1'b0;
            mag_nxt     = '0;
            state_nxt   = S_OPND1;
          end else if (head_c == K_EQ) begin
            pop_c = 1'b1;
          end else begin
            op1_nxt   = last_ans;
            state_nxt = S_OPER;
          end
        end
        S_ERROR: begin
          fnd_nxt = 32'h00EE_0000;
          if (have_c) pop_c = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
